// File: rtl/ceyloniac_pkg.sv
/************************************************************
 * ceyloniac_pkg : shared widths, occupancy states, payload type
 * Revision 1.0 : initial release
 ************************************************************/
`default_nettype none

package ceyloniac_pkg;

    localparam int ALU_DATA_WIDTH_DEF = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [ALU_DATA_WIDTH_DEF-1:0] data;
        logic [REG_ADDR_WIDTH_DEF-1:0] dest;
        logic                          zero;
    } payload_t;

endpackage

`default_nettype wire

// File: rtl/ceyloniac_alu_output_entry.sv
/************************************************************
 * ceyloniac_alu_output_entry : payload register, load + sync clear
 * Revision 1.0 : initial release
 ************************************************************/
`default_nettype none

module ceyloniac_alu_output_entry #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] payload
);

    logic [WIDTH-1:0] payload_d;
    logic [WIDTH-1:0] payload_q;

    always_comb begin
        payload_d = payload_q;
        if (clr) begin
            payload_d = '0;
        end else if (load) begin
            payload_d = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            payload_q <= '0;
        end else begin
            payload_q <= payload_d;
        end
    end

    assign payload = payload_q;

endmodule

`default_nettype wire

// File: rtl/ceyloniac_alu_output_buffer.sv
/************************************************************
 * ceyloniac_alu_output_buffer : two-entry skid buffer, ALU -> writeback
 * Revision 1.0 : initial release
 ************************************************************/
`default_nettype none

module ceyloniac_alu_output_buffer
    import ceyloniac_pkg::*;
#(
    parameter int ALU_DATA_WIDTH = ALU_DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [ALU_DATA_WIDTH-1:0] alu_output_in,
    input  logic [REG_ADDR_WIDTH-1:0] alu_dest_in,
    input  logic                      alu_valid_in,
    output logic                      alu_ready_out,
    output logic [ALU_DATA_WIDTH-1:0] alu_output_out,
    output logic [REG_ADDR_WIDTH-1:0] alu_dest_out,
    output logic                      alu_zero_out,
    output logic                      alu_valid_out,
    input  logic                      wb_ready_in,
    output logic [1:0]                occupancy
);

    localparam int PAYLOAD_WIDTH = ALU_DATA_WIDTH + REG_ADDR_WIDTH + 1;

    occ_state_e state_d;
    occ_state_e state_q;

    logic                     in_fire;
    logic                     out_fire;
    logic                     main_load;
    logic                     main_from_skid;
    logic                     skid_load;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic [PAYLOAD_WIDTH-1:0] main_payload;
    logic [PAYLOAD_WIDTH-1:0] skid_payload;
    logic [PAYLOAD_WIDTH-1:0] main_load_data;

    assign alu_ready_out = (state_q != FULL);
    assign alu_valid_out = (state_q != EMPTY);
    assign occupancy     = state_q;

    assign in_fire  = alu_valid_in & alu_ready_out;
    assign out_fire = alu_valid_out & wb_ready_in;

    // Zero flag is resolved on the input side so the output path stays flop-only.
    assign in_payload = {alu_output_in, alu_dest_in, (alu_output_in == '0)};

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_load_data = main_from_skid ? skid_payload : in_payload;

    ceyloniac_alu_output_entry #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .clr       (flush),
        .load      (main_load),
        .load_data (main_load_data),
        .payload   (main_payload)
    );

    ceyloniac_alu_output_entry #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clr       (flush),
        .load      (skid_load),
        .load_data (in_payload),
        .payload   (skid_payload)
    );

    assign alu_output_out = main_payload[PAYLOAD_WIDTH-1 -: ALU_DATA_WIDTH];
    assign alu_dest_out   = main_payload[REG_ADDR_WIDTH:1];
    assign alu_zero_out   = main_payload[0];

endmodule

`default_nettype wire

// File: tb/tb_ceyloniac_alu_output_buffer.sv
/************************************************************
 * tb_ceyloniac_alu_output_buffer : vector table + scoreboard bench
 * Revision 1.0 : initial release
 ************************************************************/
`default_nettype none

module tb_ceyloniac_alu_output_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] alu_output_in;
    logic [4:0]  alu_dest_in;
    logic        alu_valid_in;
    logic        alu_ready_out;
    logic [31:0] alu_output_out;
    logic [4:0]  alu_dest_out;
    logic        alu_zero_out;
    logic        alu_valid_out;
    logic        wb_ready_in;
    logic [1:0]  occupancy;

    logic [63:0] w_data_in;
    logic [5:0]  w_dest_in;
    logic        w_valid_in;
    logic        w_ready_out;
    logic [63:0] w_data_out;
    logic [5:0]  w_dest_out;
    logic        w_zero_out;
    logic        w_valid_out;
    logic        w_wb_ready;
    logic [1:0]  w_occ;

    ceyloniac_alu_output_buffer u_dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .alu_output_in  (alu_output_in),
        .alu_dest_in    (alu_dest_in),
        .alu_valid_in   (alu_valid_in),
        .alu_ready_out  (alu_ready_out),
        .alu_output_out (alu_output_out),
        .alu_dest_out   (alu_dest_out),
        .alu_zero_out   (alu_zero_out),
        .alu_valid_out  (alu_valid_out),
        .wb_ready_in    (wb_ready_in),
        .occupancy      (occupancy)
    );

    ceyloniac_alu_output_buffer #(
        .ALU_DATA_WIDTH (64),
        .REG_ADDR_WIDTH (6)
    ) u_dut64 (
        .clk            (clk),
        .reset          (reset),
        .flush          (1'b0),
        .alu_output_in  (w_data_in),
        .alu_dest_in    (w_dest_in),
        .alu_valid_in   (w_valid_in),
        .alu_ready_out  (w_ready_out),
        .alu_output_out (w_data_out),
        .alu_dest_out   (w_dest_out),
        .alu_zero_out   (w_zero_out),
        .alu_valid_out  (w_valid_out),
        .wb_ready_in    (w_wb_ready),
        .occupancy      (w_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        z;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [4:0]  a;
        logic        wbr;
        int          occ;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; outputs are checked against the scoreboard at the falling edge.
    task automatic step(input logic v, input logic [31:0] d, input logic [4:0] a,
                        input logic wbr, input logic fl, input int occ);
        int sz;
        alu_valid_in  = v;
        alu_output_in = d;
        alu_dest_in   = a;
        wb_ready_in   = wbr;
        flush         = fl;
        @(negedge clk);
        sz = sb.size();
        if (occ >= 0) chk("occ_table", 64'(occupancy), 64'(occ));
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("ready", 64'(alu_ready_out), 64'(sz < 2));
        chk("valid", 64'(alu_valid_out), 64'(sz != 0));
        if (sz > 0) begin
            chk("data", 64'(alu_output_out), 64'(sb[0].d));
            chk("dest", 64'(alu_dest_out), 64'(sb[0].a));
            chk("zero", 64'(alu_zero_out), 64'(sb[0].z));
            if (wbr && !fl) void'(sb.pop_front());
        end
        if (fl) begin
            sb.delete();
        end else if (v && sz < 2) begin
            sb.push_back('{d: d, a: a, z: (d == 32'h0)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_data"}, 64'(alu_output_out), 64'h0);
        chk({name, "_dest"}, 64'(alu_dest_out), 64'h0);
        chk({name, "_zero"}, 64'(alu_zero_out), 64'h0);
        chk({name, "_valid"}, 64'(alu_valid_out), 64'h0);
        chk({name, "_occ"}, 64'(occupancy), 64'h0);
        chk({name, "_ready"}, 64'(alu_ready_out), 64'h1);
    endtask

    initial begin
        // streaming
        tbl[0]  = '{1'b1, 32'd1,          5'd4, 1'b1, 0};
        tbl[1]  = '{1'b1, 32'd2,          5'd5, 1'b1, 1};
        tbl[2]  = '{1'b1, 32'd3,          5'd6, 1'b1, 1};
        tbl[3]  = '{1'b0, 32'd0,          5'd0, 1'b1, 1};
        // stall / skid, including an offer while full
        tbl[4]  = '{1'b1, 32'h10,         5'd1, 1'b0, 0};
        tbl[5]  = '{1'b1, 32'h20,         5'd2, 1'b0, 1};
        tbl[6]  = '{1'b0, 32'h0,          5'd0, 1'b0, 2};
        tbl[7]  = '{1'b1, 32'h99,         5'd7, 1'b0, 2};
        tbl[8]  = '{1'b0, 32'h0,          5'd0, 1'b1, 2};
        tbl[9]  = '{1'b0, 32'h0,          5'd0, 1'b1, 1};
        tbl[10] = '{1'b0, 32'h0,          5'd0, 1'b1, 0};
        // zero flag
        tbl[11] = '{1'b1, 32'h0,          5'd3, 1'b1, 0};
        tbl[12] = '{1'b1, 32'h8000_0000,  5'd9, 1'b1, 1};
        tbl[13] = '{1'b0, 32'h0,          5'd0, 1'b1, 1};
        tbl[14] = '{1'b0, 32'h0,          5'd0, 1'b1, 0};

        reset         = 1'b0;
        flush         = 1'b0;
        alu_valid_in  = 1'b1;
        alu_output_in = 32'hFFFF_FFFF;
        alu_dest_in   = 5'd31;
        wb_ready_in   = 1'b0;
        w_valid_in    = 1'b0;
        w_data_in     = 64'h0;
        w_dest_in     = 6'd0;
        w_wb_ready    = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk_idle_outputs("reset");
        end
        @(posedge clk);
        #1;
        reset        = 1'b1;
        alu_valid_in = 1'b0;
        w_valid_in   = 1'b1;
        w_data_in    = 64'h1_0000_0000;
        w_dest_in    = 6'd63;
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 0);
        w_valid_in = 1'b0;
        @(negedge clk);
        chk("w64_valid", 64'(w_valid_out), 64'h1);
        chk("w64_data", w_data_out, 64'h1_0000_0000);
        chk("w64_dest", 64'(w_dest_out), 64'd63);
        chk("w64_zero", 64'(w_zero_out), 64'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].wbr, 1'b0, tbl[i].occ);
        end

        // flush while full, with a coincident offered input
        step(1'b1, 32'h31, 5'd11, 1'b0, 1'b0, 0);
        step(1'b1, 32'h32, 5'd12, 1'b0, 1'b0, 1);
        step(1'b1, 32'h55, 5'd13, 1'b0, 1'b1, 2);
        @(negedge clk);
        chk_idle_outputs("flush");
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 0);
        end

        // reset while full with writeback ready: contents discarded, no transfer
        step(1'b1, 32'h41, 5'd14, 1'b0, 1'b0, 0);
        step(1'b1, 32'h42, 5'd15, 1'b0, 1'b0, 1);
        alu_valid_in = 1'b0;
        wb_ready_in  = 1'b1;
        reset        = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midreset");
        @(posedge clk);
        #1;
        step(1'b1, 32'h77, 5'd2, 1'b1, 1'b0, 0);
        step(1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1);
        step(1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
